// File: rtl/chip8_fetch_sequencer_pkg.sv
// Shared types and constants for the Chip8 instruction sequencer.
// Next-PC request codes, sequencer states and the program load address.
package chip8_pkg;

    localparam int ADDR_W = 12;
    localparam logic [ADDR_W-1:0] PC_RESET = 12'h200;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_SKIP = 3'd1,
        OP_JUMP = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HOLD = 3'd5
    } pc_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_HI,
        S_FETCH_LO,
        S_LATCH,
        S_EXEC,
        S_FAULT
    } seq_state_e;

endpackage

// File: rtl/chip8_fetch_sequencer_if.sv
// Memory bus and decode/execute handshake of the Chip8 sequencer.
// master = sequencer side, slave = memory plus datapath side.
interface chip8_fetch_sequencer_if;

    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic [2:0]  pc_op;
    logic [11:0] pc_target;

    modport master (
        output mem_rd, mem_addr, instr, instr_valid,
        input  mem_rdata, exec_done, pc_op, pc_target
    );

    modport slave (
        input  mem_rd, mem_addr, instr, instr_valid,
        output mem_rdata, exec_done, pc_op, pc_target
    );

endinterface

// File: rtl/chip8_fetch_sequencer_call_stack.sv
// Return-address LIFO for CALL/RET.
// Reset clears only the pointer; entry storage is left as-is.
module chip8_call_stack #(
    parameter int DEPTH  = 16,
    parameter int SP_W   = 5,
    parameter int DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic [DATA_W-1:0] top_o,
    output logic [SP_W-1:0]   sp_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [IDX_W-1:0]  top_idx;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign top_idx = IDX_W'(sp_q - 1'b1);
    assign top_o   = mem_q[top_idx];
    assign sp_o    = sp_q;

    // Entry storage: written on an accepted push, never reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[sp_q[IDX_W-1:0]] <= push_data_i;
        end
    end

    // Stack pointer: counts pushes up and pops down.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q <= '0;
        end else if (do_push) begin
            sp_q <= sp_q + 1'b1;
        end else if (do_pop) begin
            sp_q <= sp_q - 1'b1;
        end
    end

endmodule

// File: rtl/chip8_fetch_sequencer.sv
// Chip8 fetch sequencer: owns PC and call stack, fetches 2-byte opcodes,
// holds them for the datapath and applies its next-PC request.
import chip8_pkg::*;

module chip8_fetch_sequencer #(
    parameter logic [11:0] PC_RESET    = chip8_pkg::PC_RESET,
    parameter int          STACK_DEPTH = 16,
    parameter int          SP_W        = 5
) (
    input  logic                     cpu_clk,
    input  logic                     reset_n,
    input  logic                     run,
    chip8_fetch_sequencer_if.master  bus,
    output logic [ADDR_W-1:0]        pc,
    output logic [SP_W-1:0]          sp,
    output logic                     stack_fault
);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       instr_q;
    logic              rd_q;
    logic              valid_q;
    logic              fault_q;
    logic              fault_d;

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic              retire;

    assign retire = (state_q == S_EXEC) && bus.exec_done;

    chip8_call_stack #(
        .DEPTH  (STACK_DEPTH),
        .SP_W   (SP_W),
        .DATA_W (ADDR_W)
    ) u_stack (
        .clk_i       (cpu_clk),
        .rst_ni      (reset_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_q + 12'd2),
        .top_o       (stk_top),
        .sp_o        (sp),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    // Next-PC and stack control for the instruction retiring this cycle.
    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        fault_d = 1'b0;
        if (retire) begin
            unique case (bus.pc_op)
                OP_SKIP: pc_d = pc_q + 12'd4;
                OP_JUMP: pc_d = bus.pc_target;
                OP_CALL: begin
                    if (stk_full) begin
                        fault_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = bus.pc_target;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        fault_d = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end
                OP_HOLD: pc_d = pc_q;
                default: pc_d = pc_q + 12'd2;
            endcase
        end
    end

    // Sequencer FSM with registered bus outputs set for the next state.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            addr_q  <= '0;
            instr_q <= '0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_FETCH_HI;
                        rd_q    <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                S_FETCH_HI: begin
                    state_q <= S_FETCH_LO;
                    addr_q  <= pc_q + 12'd1;
                end
                S_FETCH_LO: begin
                    state_q       <= S_LATCH;
                    rd_q          <= 1'b0;
                    instr_q[15:8] <= bus.mem_rdata;
                end
                S_LATCH: begin
                    state_q      <= S_EXEC;
                    instr_q[7:0] <= bus.mem_rdata;
                    valid_q      <= 1'b1;
                end
                S_EXEC: begin
                    if (retire) begin
                        valid_q <= 1'b0;
                        if (fault_d) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q <= pc_d;
                            if (run) begin
                                state_q <= S_FETCH_HI;
                                rd_q    <= 1'b1;
                                addr_q  <= pc_d;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd      = rd_q;
    assign bus.mem_addr    = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign pc              = pc_q;
    assign stack_fault     = fault_q;

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
// Directed bench for chip8_fetch_sequencer: byte memory model,
// table of next-PC requests, plus hand sequences for halt/reset/faults.
module tb_chip8_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [11:0] pc;
    logic [4:0]  sp;
    logic        stack_fault;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [4096];

    chip8_fetch_sequencer_if bus ();

    chip8_fetch_sequencer #(
        .PC_RESET    (12'h200),
        .STACK_DEPTH (16),
        .SP_W        (5)
    ) dut (
        .cpu_clk     (clk),
        .reset_n     (rst_n),
        .run         (run),
        .bus         (bus),
        .pc          (pc),
        .sp          (sp),
        .stack_fault (stack_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct {
        logic [2:0]  op;
        logic [11:0] tgt;
        logic [11:0] exp_pc;
        logic [4:0]  exp_sp;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] opc(input logic [11:0] a);
        logic [11:0] b;
        b = a + 12'd1;
        return {mem[a], mem[b]};
    endfunction

    task automatic wait_valid();
        int n;
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.instr_valid !== 1'b1) chk("valid_timeout", 0, 1);
    endtask

    task automatic step(input logic [2:0] op, input logic [11:0] tgt);
        bus.exec_done = 1'b1;
        bus.pc_op     = op;
        bus.pc_target = tgt;
        @(negedge clk);
        bus.exec_done = 1'b0;
        bus.pc_op     = 3'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [11:0] cur;
        logic [11:0] nxt;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h200] = 8'h61;
        mem[12'h201] = 8'h2A;

        vecs[0]  = '{3'd0, 12'h000, 12'h202, 5'd0};
        vecs[1]  = '{3'd2, 12'h300, 12'h300, 5'd0};
        vecs[2]  = '{3'd1, 12'h000, 12'h304, 5'd0};
        vecs[3]  = '{3'd2, 12'h300, 12'h300, 5'd0};
        vecs[4]  = '{3'd2, 12'h456, 12'h456, 5'd0};
        vecs[5]  = '{3'd2, 12'h300, 12'h300, 5'd0};
        vecs[6]  = '{3'd5, 12'h123, 12'h300, 5'd0};
        vecs[7]  = '{3'd2, 12'h210, 12'h210, 5'd0};
        vecs[8]  = '{3'd3, 12'h400, 12'h400, 5'd1};
        vecs[9]  = '{3'd4, 12'h000, 12'h212, 5'd0};
        vecs[10] = '{3'd2, 12'hFFF, 12'hFFF, 5'd0};
        vecs[11] = '{3'd0, 12'h000, 12'h001, 5'd0};
        vecs[12] = '{3'd7, 12'h777, 12'h003, 5'd0};
        vecs[13] = '{3'd3, 12'h500, 12'h500, 5'd1};
        vecs[14] = '{3'd3, 12'h600, 12'h600, 5'd2};
        vecs[15] = '{3'd4, 12'h000, 12'h502, 5'd1};
        vecs[16] = '{3'd4, 12'h000, 12'h005, 5'd0};

        run           = 1'b1;
        bus.exec_done = 1'b0;
        bus.pc_op     = 3'd0;
        bus.pc_target = 12'h000;
        rst_n         = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_pc", pc, 12'h200);
        chk("rst_sp", sp, 0);
        chk("rst_rd", bus.mem_rd, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_fault", stack_fault, 0);

        // first fetch, cycle exact
        rst_n = 1'b1;
        @(negedge clk);
        chk("c1_rd", bus.mem_rd, 1);
        chk("c1_addr", bus.mem_addr, 12'h200);
        @(negedge clk);
        chk("c2_rd", bus.mem_rd, 1);
        chk("c2_addr", bus.mem_addr, 12'h201);
        @(negedge clk);
        chk("c3_rd", bus.mem_rd, 0);
        chk("c3_valid", bus.instr_valid, 0);
        @(negedge clk);
        chk("c4_valid", bus.instr_valid, 1);
        chk("c4_instr", bus.instr, 16'h612A);

        // table of next-PC requests
        cur = 12'h200;
        for (int i = 0; i < 17; i++) begin
            wait_valid();
            chk($sformatf("v%0d_instr", i), bus.instr, opc(cur));
            chk($sformatf("v%0d_pcx", i), pc, cur);
            step(vecs[i].op, vecs[i].tgt);
            chk($sformatf("v%0d_rd", i), bus.mem_rd, 1);
            chk($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].exp_pc);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_sp", i), sp, vecs[i].exp_sp);
            @(negedge clk);
            nxt = vecs[i].exp_pc + 12'd1;
            chk($sformatf("v%0d_addr2", i), bus.mem_addr, nxt);
            cur = vecs[i].exp_pc;
        end

        // run dropped during FETCH_LO of 0x005
        run = 1'b0;
        wait_valid();
        chk("halt_instr", bus.instr, opc(12'h005));
        step(3'd0, 12'h000);
        chk("halt_rd", bus.mem_rd, 0);
        chk("halt_pc", pc, 12'h007);
        repeat (3) @(negedge clk);
        chk("halt_rd2", bus.mem_rd, 0);
        chk("halt_valid", bus.instr_valid, 0);
        chk("halt_pc2", pc, 12'h007);
        run = 1'b1;
        @(negedge clk);
        chk("resume_rd", bus.mem_rd, 1);
        chk("resume_addr", bus.mem_addr, 12'h007);

        // async reset in EXEC at 0x350 with one stack entry
        wait_valid();
        step(3'd3, 12'h350);
        wait_valid();
        chk("r_pc_pre", pc, 12'h350);
        chk("r_sp_pre", sp, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pc", pc, 12'h200);
        chk("ar_valid", bus.instr_valid, 0);
        chk("ar_sp", sp, 0);
        chk("ar_rd", bus.mem_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 16 nested calls, then overflow
        for (int i = 0; i < 16; i++) begin
            wait_valid();
            step(3'd3, 12'h220);
        end
        chk("ovf_sp16", sp, 16);
        chk("ovf_nofault", stack_fault, 0);
        wait_valid();
        step(3'd3, 12'h600);
        chk("ovf_fault", stack_fault, 1);
        chk("ovf_rd", bus.mem_rd, 0);
        chk("ovf_valid", bus.instr_valid, 0);
        chk("ovf_sp", sp, 16);
        chk("ovf_pc", pc, 12'h220);
        bus.exec_done = 1'b1;
        bus.pc_op     = 3'd4;
        repeat (4) @(negedge clk);
        bus.exec_done = 1'b0;
        chk("fault_rd", bus.mem_rd, 0);
        chk("fault_sticky", stack_fault, 1);
        chk("fault_sp", sp, 16);

        // underflow right after reset
        do_reset();
        chk("unf_clr", stack_fault, 0);
        wait_valid();
        step(3'd4, 12'h000);
        chk("unf_fault", stack_fault, 1);
        chk("unf_pc", pc, 12'h200);
        chk("unf_sp", sp, 0);
        chk("unf_rd", bus.mem_rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
